trig_capture: RTL and testbench

Trigger-driven sample recorder that consumes the threshold trigger output and the registered 14-bit ADC stream from the trigger stage. When armed, it writes ADC samples continuously into a circular buffer. On a trigger rising edge, it freezes a window of PRE_LEN pre-trigger samples plus a programmable number of post-trigger samples. The window is then read back by the processor-side register bank, oldest sample first.

---
 rtl/trig_capture_pkg.sv | 22 ++
 rtl/capture_ram.sv | 29 ++
 rtl/trig_capture.sv | 156 +++++++++++++++
 tb/tb_trig_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_capture_pkg.sv
// Shared constants and state encoding for the trigger-driven sample recorder.
package trig_capture_pkg;

  localparam int DEF_DW      = 14;
  localparam int DEF_AW      = 10;
  localparam int DEF_PRE_LEN = 128;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRE_FILL  = 3'd1;
  localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
  localparam logic [2:0] ST_POST      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    PRE_FILL  = ST_PRE_FILL,
    WAIT_TRIG = ST_WAIT_TRIG,
    POST      = ST_POST,
    DONE      = ST_DONE
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram #(
  parameter int DW = 14,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_q;

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/trig_capture.sv
// Trigger-driven recorder: circular capture of ADC samples, freezing a
// pre/post-trigger window that is read back oldest sample first.
module trig_capture
  import trig_capture_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int PRE_LEN = DEF_PRE_LEN
) (
  input  logic          adc_clk,
  input  logic          adc_rstn,
  input  logic          arm,
  input  logic          trig_in,
  input  logic [DW-1:0] adc_dat_in,
  input  logic [AW-1:0] post_len,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic          trig_seen
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] MAX_POST = (AW+1)'(DEPTH - PRE_LEN);
  localparam logic [AW:0] PRE_M1   = (AW+1)'(PRE_LEN - 1);
  localparam logic [AW-1:0] PRE_A  = AW'(PRE_LEN);

  // Zero requests one sample; anything past the free space is clamped.
  function automatic logic [AW:0] eff_post(input logic [AW-1:0] len);
    logic [AW:0] w_len;
    w_len = {1'b0, len};
    if (w_len == '0) begin
      return (AW+1)'(1);
    end
    if (w_len > MAX_POST) begin
      return MAX_POST;
    end
    return w_len;
  endfunction

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_start_ptr;
  logic [AW:0]   r_cnt;
  logic          r_trig_d;
  logic          r_trig_seen;
  logic          r_rd_vld;
  logic          w_we;
  logic          w_acc;
  logic          w_edge;
  logic [AW:0]   w_eff;
  logic [AW-1:0] w_raddr;
  logic [DW-1:0] w_ram_q;

  assign w_edge  = trig_in & ~r_trig_d;
  assign w_raddr = r_start_ptr + rd_addr;

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_we   = 1'b0;
    w_acc  = 1'b0;
    w_eff  = eff_post(post_len);
    case (r_state)
      IDLE: begin
      end
      PRE_FILL: begin
        w_we = 1'b1;
        if (r_cnt == PRE_M1) begin
          w_next = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        w_we = 1'b1;
        if (w_edge) begin
          w_acc = 1'b1;
          // A single post sample is the edge sample itself, so skip POST.
          w_next = (w_eff == (AW+1)'(1)) ? DONE : POST;
        end
      end
      POST: begin
        w_we = 1'b1;
        if (r_cnt == (AW+1)'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
      end
      default: w_next = IDLE;
    endcase
    if (arm) begin
      w_next = PRE_FILL;
      w_we   = 1'b0;
      w_acc  = 1'b0;
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_cnt       <= '0;
      r_trig_d    <= 1'b0;
      r_trig_seen <= 1'b0;
      r_rd_vld    <= 1'b0;
    end else begin
      r_trig_d    <= trig_in;
      r_trig_seen <= w_acc;
      r_rd_vld    <= 1'b1;
      if (arm) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        // In POST the counter holds the post samples still to be written.
        if (w_acc) begin
          r_start_ptr <= r_wr_ptr - PRE_A;
          r_cnt       <= w_eff - 1'b1;
        end else if (r_state == PRE_FILL) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (r_state == POST) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  capture_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .i_clk   (adc_clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc_dat_in),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // Masks the uninitialised RAM read register until the first clock after reset.
  assign rd_data   = r_rd_vld ? w_ram_q : '0;
  assign busy      = (r_state == PRE_FILL) || (r_state == WAIT_TRIG) || (r_state == POST);
  assign done      = (r_state == DONE);
  assign trig_seen = r_trig_seen;

endmodule

// File: tb/tb_trig_capture.sv
// Scenario bench for trig_capture: ramp stimulus, window readback via a
// scoreboard queue of expected samples.
module tb_trig_capture;

  localparam int DW    = 14;
  localparam int AW    = 10;
  localparam int PRE   = 128;
  localparam int DEPTH = 1024;

  logic          adc_clk  = 1'b0;
  logic          adc_rstn = 1'b1;
  logic          arm      = 1'b0;
  logic          trig_in  = 1'b0;
  logic [DW-1:0] adc_dat_in = '0;
  logic [AW-1:0] post_len   = '0;
  logic [AW-1:0] rd_addr    = '0;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          trig_seen;

  int            total = 0;
  int            bad   = 0;
  int            samp  = 0;
  logic [DW-1:0] exp_q [$];

  always #5 adc_clk = ~adc_clk;

  trig_capture #(
    .DW      (DW),
    .AW      (AW),
    .PRE_LEN (PRE)
  ) dut (
    .adc_clk    (adc_clk),
    .adc_rstn   (adc_rstn),
    .arm        (arm),
    .trig_in    (trig_in),
    .adc_dat_in (adc_dat_in),
    .post_len   (post_len),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .trig_seen  (trig_seen)
  );

  task automatic tick();
    @(posedge adc_clk);
    #1;
    samp++;
    adc_dat_in = DW'(samp);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic fill_pre();
    repeat (PRE) tick();
  endtask

  // Presents a rising trigger on the current sample, then runs until done.
  task automatic fire(input logic [AW-1:0] plen, output logic [DW-1:0] ev,
                      output logic seen, output int cyc);
    post_len = plen;
    ev       = adc_dat_in;
    trig_in  = 1'b1;
    tick();
    seen    = trig_seen;
    trig_in = 1'b0;
    cyc     = 1;
    while (!done && cyc < 2000) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    logic flag;
    #2 adc_rstn = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
    total++; if (trig_seen !== 1'b0) begin bad++; $display("FAIL rst_trig_seen got=%0b want=0", trig_seen); end
    total++; if (rd_data !== '0) begin bad++; $display("FAIL rst_rd_data got=%0d want=0", rd_data); end
    adc_rstn = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 100; i++) begin
      trig_in = ~trig_in;
      tick();
      if (trig_seen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) flag = 1'b1;
    end
    trig_in = 1'b0;
    tick();
    total++; if (flag !== 1'b0) begin bad++; $display("FAIL idle_activity got=%0b want=0", flag); end
  endtask

  task automatic test_ramp();
    logic [DW-1:0] ev;
    logic [DW-1:0] want;
    logic          seen;
    int            cyc;
    pulse_arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_busy_after_arm got=%0b want=1", busy); end
    fill_pre();
    for (int n = 0; n < 20000 && adc_dat_in != 14'd1000; n++) tick();
    fire(10'd256, ev, seen, cyc);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL ramp_trig_seen got=%0b want=1", seen); end
    total++; if (cyc != 256) begin bad++; $display("FAIL ramp_done_latency got=%0d want=256", cyc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp_busy_done got=%0b want=0", busy); end
    for (int k = 0; k < 384; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(872 + k));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL ramp_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
  endtask

  task automatic test_prefill_ignore();
    logic [DW-1:0] a;
    logic [DW-1:0] ev;
    logic [DW-1:0] want;
    logic          seen;
    logic          flag;
    int            cyc;
    a = adc_dat_in;
    pulse_arm();
    flag = 1'b0;
    for (int i = 1; i <= PRE; i++) begin
      trig_in = ((i >= 20 && i < 30) || (i >= 100 && i < 110) || i == 127);
      tick();
      if (trig_seen !== 1'b0 || busy !== 1'b1) flag = 1'b1;
    end
    total++; if (flag !== 1'b0) begin bad++; $display("FAIL pre_trig_ignored got=%0b want=0", flag); end
    fire(10'd16, ev, seen, cyc);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL pre_first_edge got=%0b want=1", seen); end
    total++; if (ev !== DW'(a + 14'd129)) begin bad++; $display("FAIL pre_edge_sample got=%0d want=%0d", ev, DW'(a + 14'd129)); end
    total++; if (cyc != 16) begin bad++; $display("FAIL pre_done_latency got=%0d want=16", cyc); end
    for (int k = 0; k < PRE + 16; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(a + 14'd1 + DW'(k)));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL pre_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ev;
    logic [DW-1:0] want;
    logic          seen;
    int            cyc;
    pulse_arm();
    fill_pre();
    repeat (3 * DEPTH + 300) tick();
    fire(10'd100, ev, seen, cyc);
    total++; if (cyc != 100) begin bad++; $display("FAIL wrap_done_latency got=%0d want=100", cyc); end
    for (int k = 0; k < PRE + 100; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(ev - 14'd128 + DW'(k)));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL wrap_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
  endtask

  task automatic test_post_len_limits();
    logic [DW-1:0] ev;
    logic [DW-1:0] want;
    logic          seen;
    int            cyc;
    pulse_arm();
    fill_pre();
    fire(10'd0, ev, seen, cyc);
    total++; if (cyc != 1) begin bad++; $display("FAIL post0_done_latency got=%0d want=1", cyc); end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL post0_trig_seen got=%0b want=1", seen); end
    for (int k = 0; k < PRE + 1; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(ev - 14'd128 + DW'(k)));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL post0_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
    pulse_arm();
    fill_pre();
    fire(10'd1023, ev, seen, cyc);
    total++; if (cyc != 896) begin bad++; $display("FAIL clamp_done_latency got=%0d want=896", cyc); end
    for (int k = 0; k < DEPTH; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(ev - 14'd128 + DW'(k)));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL clamp_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
  endtask

  task automatic test_arm_restart();
    logic [DW-1:0] ev;
    logic [DW-1:0] want;
    logic          seen;
    logic          flag;
    int            cyc;
    pulse_arm();
    fill_pre();
    post_len = 10'd200;
    trig_in  = 1'b1;
    tick();
    trig_in = 1'b0;
    total++; if (trig_seen !== 1'b1) begin bad++; $display("FAIL restart_first_edge got=%0b want=1", trig_seen); end
    repeat (50) tick();
    pulse_arm();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%0b want=1", busy); end
    flag = 1'b0;
    for (int i = 0; i < PRE + 300; i++) begin
      tick();
      if (done !== 1'b0 || trig_seen !== 1'b0) flag = 1'b1;
    end
    total++; if (flag !== 1'b0) begin bad++; $display("FAIL restart_old_discarded got=%0b want=0", flag); end
    trig_in = 1'b1;
    arm     = 1'b1;
    tick();
    arm     = 1'b0;
    trig_in = 1'b0;
    total++; if (trig_seen !== 1'b0) begin bad++; $display("FAIL arm_beats_edge got=%0b want=0", trig_seen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arm_edge_busy got=%0b want=1", busy); end
    fill_pre();
    fire(10'd64, ev, seen, cyc);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL restart_new_edge got=%0b want=1", seen); end
    total++; if (cyc != 64) begin bad++; $display("FAIL restart_done_latency got=%0d want=64", cyc); end
    for (int k = 0; k < PRE + 64; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(DW'(ev - 14'd128 + DW'(k)));
      tick();
      want = exp_q.pop_front();
      total++;
      if (rd_data !== want) begin bad++; $display("FAIL restart_rd[%0d] got=%0d want=%0d", k, rd_data, want); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_prefill_ignore();
    test_wrap();
    test_post_len_limits();
    test_arm_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
